// File: rtl/exu_pkg.sv
// Shared types for the execute stage: operation codes, FSM states and access sizes.
package exu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_COPY2  = 5'd10,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } op_e;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   localparam logic [1:0] MSIZE_B = 2'd0;
   localparam logic [1:0] MSIZE_H = 2'd1;
   localparam logic [1:0] MSIZE_W = 2'd2;
   localparam logic [1:0] MSIZE_D = 2'd3;

   function automatic logic is_md(input logic [4:0] op);
      return op[4];
   endfunction

endpackage

// File: rtl/exu_muldiv.sv
// Iterative multiply (shift-add) / restoring divide on operand magnitudes.
// XLEN iteration cycles plus one sign-fixup cycle in which done pulses.
module exu_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            kill,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic            busy_q, fix_q, mul_q, hsel_q, rem_q, neg_q, bz_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] m_q, acc_q, lo_q;

   logic            is_mul, is_rem, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   sum, rsh, diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo, rmd;

   always_comb begin
      is_mul = !op[2];
      is_rem = op[2] & op[1];
      // a is signed except MULHU/DIVU/REMU; b only for MUL/MULH/DIV/REM
      a_neg  = a[XLEN-1] & (is_mul ? (op[1:0] != 2'b11) : !op[0]);
      b_neg  = b[XLEN-1] & (is_mul ? !op[1] : !op[0]);
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
   end

   always_comb begin
      sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      rsh  = {acc_q, lo_q[XLEN-1]};
      // partial remainder stays below the divisor, so diff's MSB is its sign
      diff = rsh - {1'b0, m_q};
      prod = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
      quo  = bz_q ? '1 : (neg_q ? -lo_q : lo_q);
      rmd  = neg_q ? -acc_q : acc_q;
      if (mul_q) result = hsel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      else       result = rem_q ? rmd : quo;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= 1'b0;
         fix_q  <= 1'b0;
         mul_q  <= 1'b0;
         hsel_q <= 1'b0;
         rem_q  <= 1'b0;
         neg_q  <= 1'b0;
         bz_q   <= 1'b0;
         cnt_q  <= '0;
         m_q    <= '0;
         acc_q  <= '0;
         lo_q   <= '0;
      end else if (kill) begin
         busy_q <= 1'b0;
         fix_q  <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         fix_q  <= 1'b0;
         cnt_q  <= CW'(XLEN-1);
         mul_q  <= is_mul;
         hsel_q <= (op[1:0] != 2'b00);
         rem_q  <= is_rem;
         neg_q  <= a_neg ^ (b_neg & !is_rem);
         bz_q   <= (b == '0);
         m_q    <= is_mul ? a_mag : b_mag;
         lo_q   <= is_mul ? b_mag : a_mag;
         acc_q  <= '0;
      end else if (fix_q) begin
         busy_q <= 1'b0;
         fix_q  <= 1'b0;
      end else if (busy_q) begin
         if (mul_q) begin
            acc_q <= sum[XLEN:1];
            lo_q  <= {sum[0], lo_q[XLEN-1:1]};
         end else begin
            acc_q <= diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
            lo_q  <= {lo_q[XLEN-2:0], !diff[XLEN]};
         end
         if (cnt_q == '0) fix_q <= 1'b1;
         else             cnt_q <= cnt_q - 1'b1;
      end
   end

   assign busy = busy_q;
   assign done = fix_q;

endmodule

// File: rtl/exu_pipe.sv
// Execute stage: single-cycle ALU, iterative MD unit, store lane/mask generation,
// and valid/ready handshakes with a registered output stage.
module exu_pipe
   import exu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 128,
   parameter bit MD_EN     = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [4:0]           in_op_i,
   input  logic [XLEN-1:0]      in_src1_i,
   input  logic [XLEN-1:0]      in_src2_i,
   input  logic [XLEN-1:0]      in_sdata_i,
   input  logic [1:0]           in_msize_i,
   input  logic                 in_mwe_i,
   input  logic                 in_mre_i,
   input  logic [PAYLOAD_W-1:0] in_payload_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      out_result_o,
   output logic [XLEN-1:0]      out_wdata_o,
   output logic [XLEN/8-1:0]    out_wmask_o,
   output logic                 out_mwe_o,
   output logic                 out_mre_o,
   output logic                 out_misalign_o,
   output logic [PAYLOAD_W-1:0] out_payload_o
);

   localparam int SHW  = $clog2(XLEN);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   state_e            state_q, state_d;
   logic              accept, mem, md_go, mis_c, md_busy, md_done, md_fin;
   logic [4:0]        op_eff;
   logic [SHW-1:0]    shamt;
   logic [OFFW-1:0]   off;
   logic [XLEN-1:0]   alu_res, wdata_c, md_result;
   logic [NB-1:0]     wmask_c;

   // memory requests always compute src1+src2; MD ops fall back to ADD without the unit
   always_comb begin
      mem    = in_mwe_i | in_mre_i;
      op_eff = in_op_i;
      if (mem || (is_md(in_op_i) && !MD_EN)) op_eff = OP_ADD;
      md_go  = is_md(op_eff);
      shamt  = in_src2_i[SHW-1:0];
      case (op_e'(op_eff))
         OP_SUB:   alu_res = in_src1_i - in_src2_i;
         OP_SLL:   alu_res = in_src1_i << shamt;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(in_src1_i) < $signed(in_src2_i)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, in_src1_i < in_src2_i};
         OP_XOR:   alu_res = in_src1_i ^ in_src2_i;
         OP_SRL:   alu_res = in_src1_i >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(in_src1_i) >>> shamt);
         OP_OR:    alu_res = in_src1_i | in_src2_i;
         OP_AND:   alu_res = in_src1_i & in_src2_i;
         OP_COPY2: alu_res = in_src2_i;
         default:  alu_res = in_src1_i + in_src2_i;
      endcase
   end

   always_comb begin
      off = alu_res[OFFW-1:0];
      for (int i = 0; i < NB; i++)
         wmask_c[i] = (i >= int'(off)) && (i < int'(off) + (1 << in_msize_i));
      mis_c   = ((int'(off) & ((1 << in_msize_i) - 1)) != 0) ||
                (XLEN == 32 && in_msize_i == MSIZE_D);
      wdata_c = in_sdata_i << {off, 3'b000};
   end

   generate
      if (MD_EN) begin : g_md
         exu_muldiv #(.XLEN(XLEN)) u_md (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .kill    (flush_i),
            .start   (accept && md_go),
            .op      (in_op_i[2:0]),
            .a       (in_src1_i),
            .b       (in_src2_i),
            .busy    (md_busy),
            .done    (md_done),
            .result  (md_result)
         );
      end else begin : g_nomd
         assign md_busy   = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate

   always_comb begin
      in_ready_o = !flush_i && (state_q == S_IDLE || (state_q == S_DONE && out_ready_i));
      accept     = in_valid_i && in_ready_o;
      md_fin     = md_busy && md_done;
      state_d    = state_q;
      if (flush_i) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = md_go ? S_BUSY : S_DONE;
            S_BUSY:  if (md_fin) state_d = S_DONE;
            S_DONE:  if (out_ready_i) state_d = accept ? (md_go ? S_BUSY : S_DONE) : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_result_o   <= '0;
         out_wdata_o    <= '0;
         out_wmask_o    <= '0;
         out_mwe_o      <= 1'b0;
         out_mre_o      <= 1'b0;
         out_misalign_o <= 1'b0;
         out_payload_o  <= '0;
      end else if (accept) begin
         out_payload_o <= in_payload_i;
         if (md_go) begin
            out_wdata_o    <= '0;
            out_wmask_o    <= '0;
            out_mwe_o      <= 1'b0;
            out_mre_o      <= 1'b0;
            out_misalign_o <= 1'b0;
         end else begin
            out_result_o   <= alu_res;
            out_wdata_o    <= mem ? wdata_c : '0;
            out_wmask_o    <= (mem && !mis_c) ? wmask_c : '0;
            out_mwe_o      <= in_mwe_i && !mis_c;
            out_mre_o      <= in_mre_i && !mis_c;
            out_misalign_o <= mem && mis_c;
         end
      end else if (state_q == S_BUSY && md_fin && !flush_i) begin
         out_result_o <= md_result;
      end
   end

   assign out_valid_o = (state_q == S_DONE);

endmodule

// File: tb/tb_exu_pipe.sv
// Bench for exu_pipe (XLEN=32): directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_exu_pipe;
   import exu_pkg::*;

   localparam int XLEN = 32;
   localparam int PW   = 128;

   logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic            mwe = 1'b0, mre = 1'b0;
   logic [4:0]      op = 5'd0;
   logic [31:0]     s1 = '0, s2 = '0, sd = '0;
   logic [1:0]      msize = '0;
   logic [PW-1:0]   pl = '0;

   logic            in_ready_o, out_valid_o, out_mwe_o, out_mre_o, out_misalign_o;
   logic [31:0]     out_result_o, out_wdata_o;
   logic [3:0]      out_wmask_o;
   logic [PW-1:0]   out_payload_o;

   int n_chk = 0, n_pass = 0;

   exu_pipe #(.XLEN(XLEN), .PAYLOAD_W(PW), .MD_EN(1'b1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_op_i(op),
      .in_src1_i(s1), .in_src2_i(s2), .in_sdata_i(sd), .in_msize_i(msize),
      .in_mwe_i(mwe), .in_mre_i(mre), .in_payload_i(pl),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready),
      .out_result_o(out_result_o), .out_wdata_o(out_wdata_o), .out_wmask_o(out_wmask_o),
      .out_mwe_o(out_mwe_o), .out_mre_o(out_mre_o), .out_misalign_o(out_misalign_o),
      .out_payload_o(out_payload_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint pa, pb;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa = a; sb = b;
      pa = longint'(sa); pb = longint'(sb);
      ua = {32'b0, a};   ub = {32'b0, b};
      case (o)
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_SLL:    return a << b[4:0];
         OP_SLT:    return {31'b0, sa < sb};
         OP_SLTU:   return {31'b0, a < b};
         OP_XOR:    return a ^ b;
         OP_SRL:    return a >> b[4:0];
         OP_SRA:    return $unsigned(sa >>> b[4:0]);
         OP_OR:     return a | b;
         OP_AND:    return a & b;
         OP_COPY2:  return b;
         OP_MUL:    begin p = ua * ub;            return p[31:0];  end
         OP_MULH:   begin p = pa * pb;            return p[63:32]; end
         OP_MULHSU: begin p = pa * longint'(ub);  return p[63:32]; end
         OP_MULHU:  begin p = ua * ub;            return p[63:32]; end
         OP_DIV:    if (b == 0) return '1;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    else return sa / sb;
         OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    if (b == 0) return a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                    else return sa % sb;
         OP_REMU:   return (b == 0) ? a : a % b;
         default:   return a + b;
      endcase
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // one transaction with out_ready held high; checks latency and every output
   task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic [1:0] ms,
                         input logic we, input logic re);
      logic [PW-1:0] p;
      logic [31:0]   addr, ewd;
      logic [3:0]    emask;
      int            lat, wt, rdy_busy, off, nb, m;
      bit            is_mem, md, mis;
      p = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      op = o; s1 = a; s2 = b; sd = d; msize = ms; mwe = we; mre = re; pl = p; in_valid = 1'b1;
      wt = 0;
      while (!in_ready_o && wt < 100) begin @(negedge clk); wt++; end
      chk({tag, " accept"}, (wt < 100), 1);
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0; rdy_busy = 0;
      @(negedge clk);
      while (!out_valid_o && lat < 200) begin
         if (in_ready_o) rdy_busy++;
         @(negedge clk); lat++;
      end
      is_mem = we | re;
      md     = o[4] && !is_mem;
      chk({tag, " lat"}, lat, md ? XLEN + 1 : 0);
      chk({tag, " valid"}, out_valid_o, 1);
      chk({tag, " result"}, out_result_o, ref_res(is_mem ? 5'(OP_ADD) : o, a, b));
      chk({tag, " payload"}, out_payload_o, p);
      if (md) chk({tag, " ready busy"}, rdy_busy, 0);
      if (is_mem) begin
         addr  = a + b;
         off   = int'(addr[1:0]);
         nb    = 1 << ms;
         mis   = ((off % nb) != 0) || (ms == 2'd3);
         m     = ((1 << nb) - 1) << off;
         emask = mis ? 4'b0 : m[3:0];
         ewd   = d << (8 * off);
         chk({tag, " wmask"}, out_wmask_o, emask);
         chk({tag, " wdata"}, out_wdata_o, ewd);
         chk({tag, " misalign"}, out_misalign_o, mis);
         chk({tag, " mwe"}, out_mwe_o, we && !mis);
         chk({tag, " mre"}, out_mre_o, re && !mis);
      end else begin
         chk({tag, " wmask"}, out_wmask_o, 0);
         chk({tag, " mem en"}, {out_mwe_o, out_mre_o, out_misalign_o}, 0);
      end
   endtask

   logic [4:0] ops [19] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                            OP_OR, OP_AND, OP_COPY2, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                            OP_DIV, OP_DIVU, OP_REM, OP_REMU};

   initial begin
      logic [PW-1:0] p;
      logic [4:0]    o;
      logic [31:0]   a, b;
      logic [1:0]    ms;
      logic          we;
      int            cnt;

      // reset state
      #12;
      chk("rst valid", out_valid_o, 0);
      chk("rst ready", in_ready_o, 1);
      chk("rst result", out_result_o, 0);
      chk("rst wdata", out_wdata_o, 0);
      chk("rst wmask", out_wmask_o, 0);
      chk("rst mem", {out_mwe_o, out_mre_o, out_misalign_o}, 0);
      chk("rst payload", out_payload_o, 0);
      @(negedge clk); rst_n = 1'b1;

      run_op("add", OP_ADD, 32'h10, 32'h20, 0, 2'd0, 0, 0);

      // four ADDs on consecutive edges
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         op = OP_ADD; s1 = 32'(i * 16); s2 = 32'(i + 1); mwe = 0; mre = 0; in_valid = 1'b1;
         chk("b2b ready", in_ready_o, 1);
         @(posedge clk); #1;
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
         chk("b2b valid", out_valid_o, 1);
         chk("b2b result", out_result_o, i * 16 + i + 1);
      end

      run_op("sb",  OP_ADD, 32'h1000, 32'd3, 32'hAB, 2'd0, 1, 0);
      run_op("sw misalign", OP_ADD, 32'h1000, 32'd2, 32'h1234_5678, 2'd2, 1, 0);
      run_op("lh", OP_ADD, 32'h2000, 32'd2, 32'h0, 2'd1, 0, 1);
      run_op("ld on rv32", OP_ADD, 32'h2000, 32'd0, 32'h0, 2'd3, 0, 1);
      run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
      run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
      run_op("divu 0", OP_DIVU, 32'd7, 32'd0, 0, 2'd0, 0, 0);
      run_op("remu 0", OP_REMU, 32'd7, 32'd0, 0, 2'd0, 0, 0);
      run_op("div 0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 2'd0, 0, 0);
      run_op("rem 0", OP_REM, 32'hFFFF_FFF9, 32'd0, 0, 2'd0, 0, 0);
      run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
      run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
      run_op("mul", OP_MUL, 32'h1234_5678, 32'd2, 0, 2'd0, 0, 0);
      run_op("sra", OP_SRA, 32'h8000_00F0, 32'h24, 0, 2'd0, 0, 0);

      // backpressure: SH held for several cycles, next request waits, then goes same cycle
      p = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      out_ready = 1'b0;
      op = OP_ADD; s1 = 32'h2000; s2 = 32'd2; sd = 32'hBEEF; msize = 2'd1; mwe = 1; mre = 0;
      pl = p; in_valid = 1'b1;
      @(posedge clk); #1;
      s1 = 32'd100; s2 = 32'd1; msize = 2'd0; mwe = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp valid", out_valid_o, 1);
         chk("bp ready", in_ready_o, 0);
         chk("bp result", out_result_o, 32'h2002);
         chk("bp wmask", out_wmask_o, 4'b1100);
         chk("bp wdata", out_wdata_o, 32'hBEEF_0000);
         chk("bp mwe", out_mwe_o, 1);
         chk("bp payload", out_payload_o, p);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp release ready", in_ready_o, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp next valid", out_valid_o, 1);
      chk("bp next result", out_result_o, 32'd101);
      chk("bp next wmask", out_wmask_o, 0);

      // flush in the tenth BUSY cycle of a divide
      @(negedge clk);
      op = OP_DIV; s1 = 32'd100; s2 = 32'd7; mwe = 0; mre = 0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; op = OP_ADD; s1 = 32'd1; s2 = 32'd2; in_valid = 1'b1;
      #1 chk("flush ready", in_ready_o, 0);
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush valid", out_valid_o, 0);
      chk("flush idle", in_ready_o, 1);
      cnt = 0;
      repeat (40) begin @(negedge clk); if (out_valid_o) cnt++; end
      chk("flush no output", cnt, 0);

      // asynchronous reset mid-iteration
      @(negedge clk);
      op = OP_DIVU; s1 = 32'd1000; s2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("busy ready", in_ready_o, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("areset valid", out_valid_o, 0);
      chk("areset ready", in_ready_o, 1);
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin @(negedge clk); if (out_valid_o) cnt++; end
      chk("areset no output", cnt, 0);
      run_op("post reset", OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 2'd0, 0, 0);

      // randomized ops and memory accesses
      for (int k = 0; k < 40; k++) begin
         o = ops[$urandom_range(0, 18)];
         a = rnd();
         b = rnd();
         ms = 2'd0;
         we = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            o  = OP_ADD;
            b  = 32'($urandom_range(0, 7));
            ms = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            run_op("rand mem", o, a, b, $urandom, ms, we, !we);
         end else begin
            run_op("rand op", o, a, b, $urandom, ms, 1'b0, 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
